// File: rtl/rsa_modexp_core_if.sv
`default_nettype none
// ============================================================================
// Module      : rsa_modexp_core_if
// Description : Request/response bundle for the RSA modular-exponentiation
//               core. The master side issues a one-cycle start together with
//               mode, operands and both keys. The slave side returns the
//               result, a one-cycle done, busy and error.
// Ports       : start, mode, msg, e_key, d_key, n   (master -> slave)
//               result, done, busy, error           (slave -> master)
// Revision    : 1.0  initial release
// ============================================================================
interface rsa_modexp_core_if #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = 128
);
  logic                 start;
  logic                 mode;
  logic [WIDTH-1:0]     msg;
  logic [EXP_WIDTH-1:0] e_key;
  logic [EXP_WIDTH-1:0] d_key;
  logic [WIDTH-1:0]     n;
  logic [WIDTH-1:0]     result;
  logic                 done;
  logic                 busy;
  logic                 error;

  modport master (
    output start, mode, msg, e_key, d_key, n,
    input  result, done, busy, error
  );

  modport slave (
    input  start, mode, msg, e_key, d_key, n,
    output result, done, busy, error
  );
endinterface
`default_nettype wire

// File: rtl/rsa_modexp_core.sv
`default_nettype none
// ============================================================================
// Module      : rsa_modexp_core
// Description : Sequential constant-time RSA modular exponentiation,
//               result = msg^key mod n, using right-to-left binary
//               exponentiation. Each exponent bit costs WIDTH cycles of two
//               parallel bit-serial interleaved modular multipliers: R*B and
//               B*B. The key is taken from e_key (mode=0) or d_key (mode=1).
// Ports       : clock  - rising-edge clock
//               reset  - asynchronous active-low reset
//               bus    - rsa_modexp_core_if.slave (start/mode/msg/e_key/
//                        d_key/n in; result/done/busy/error out)
// Revision    : 1.0  initial release
// ============================================================================
module rsa_modexp_core #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = 128
) (
  input  wire logic         clock,
  input  wire logic         reset,
  rsa_modexp_core_if.slave  bus
);

  localparam int JW = (WIDTH > 1)     ? $clog2(WIDTH)     : 1;
  localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     msg_q;
  logic [WIDTH-1:0]     n_q;
  logic [EXP_WIDTH-1:0] key_q;
  logic [WIDTH-1:0]     r_q;      // running product R
  logic [WIDTH-1:0]     b_q;      // running square B = msg^(2^k)
  logic [WIDTH:0]       acc1;     // R*B partial remainder
  logic [WIDTH:0]       acc2;     // B*B partial remainder
  logic [JW-1:0]        j;        // multiplier operand bit, MSB first
  logic [KW-1:0]        k;        // exponent bit, LSB first

  logic [WIDTH:0]       next1;
  logic [WIDTH:0]       next2;

  // One step of an interleaved modular multiply. acc < m holds on entry, so
  // 2*acc and the subsequent add each need at most one conditional subtract,
  // and one extra bit of headroom is enough.
  function automatic logic [WIDTH:0] mod_step(
    input logic [WIDTH:0]   acc,
    input logic             a_bit,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH:0] t;
    logic [WIDTH:0] mm;
    mm = {1'b0, m};
    t  = acc << 1;
    if (t >= mm) t = t - mm;
    if (a_bit) begin
      t = t + {1'b0, b};
      if (t >= mm) t = t - mm;
    end
    return t;
  endfunction

  always_comb begin
    next1 = mod_step(acc1, r_q[j], b_q, n_q);
    next2 = mod_step(acc2, b_q[j], b_q, n_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      msg_q      <= '0;
      n_q        <= '0;
      key_q      <= '0;
      r_q        <= '0;
      b_q        <= '0;
      acc1       <= '0;
      acc2       <= '0;
      j          <= '0;
      k          <= '0;
      bus.result <= '0;
      bus.done   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.error  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            msg_q    <= bus.msg;
            n_q      <= bus.n;
            key_q    <= bus.mode ? bus.d_key : bus.e_key;
            bus.busy <= 1'b1;
            state    <= CHECK;
          end
        end

        CHECK: begin
          if ((n_q < WIDTH'(2)) || (msg_q >= n_q)) begin
            // Invalid operands: report on the next cycle with result 0.
            bus.result <= '0;
            bus.error  <= 1'b1;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            r_q   <= WIDTH'(1);
            b_q   <= msg_q;
            acc1  <= '0;
            acc2  <= '0;
            j     <= JW'(WIDTH - 1);
            k     <= '0;
            state <= MUL;
          end
        end

        MUL: begin
          if (j == '0) begin
            // Both products are complete this cycle. R only takes its
            // product when the key bit is set, but the work is identical
            // either way so timing does not depend on the key.
            acc1 <= '0;
            acc2 <= '0;
            j    <= JW'(WIDTH - 1);
            b_q  <= next2[WIDTH-1:0];
            if (key_q[k]) r_q <= next1[WIDTH-1:0];
            if (k == KW'(EXP_WIDTH - 1)) begin
              bus.result <= key_q[k] ? next1[WIDTH-1:0] : r_q;
              bus.error  <= 1'b0;
              bus.done   <= 1'b1;
              state      <= DONE;
            end else begin
              k <= k + KW'(1);
            end
          end else begin
            acc1 <= next1;
            acc2 <= next2;
            j    <= j - JW'(1);
          end
        end

        DONE: begin
          // start is deliberately not looked at here.
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/rsa_modexp_core.md
# rsa_modexp_core

Parametrised sequential RSA modular-exponentiation engine computing `result = msg^key mod n`, with per-operation encrypt/decrypt key selection and operand validity checking. It replaces the fixed-width encrypt-only core behind the 128-bit UART transceiver. It is driven by the same single-cycle start pulse derived from the receive strobe, and returns a one-cycle `done` that the top level turns into `tx_wr`. The schedule is constant-time: every exponent bit costs the same number of cycles regardless of key value.

## Interface
- `WIDTH`, 128: modulus, message and result width in bits.
- `EXP_WIDTH`, 128: key width in bits; fixes the iteration count.

- `clock` in 1: sole clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state and outputs.
- `start` in 1: one-cycle request; sampled only in IDLE, ignored while `busy`.
- `mode` in 1: 0 selects `e_key` (encrypt), 1 selects `d_key` (decrypt); sampled with `start`.
- `msg` in WIDTH: message or ciphertext; sampled with `start`.
- `e_key` in EXP_WIDTH: public exponent.
- `d_key` in EXP_WIDTH: private exponent.
- `n` in WIDTH: modulus; sampled with `start`.
- `result` out WIDTH: last computed value; held until the next completion.
- `done` out 1: one-cycle pulse when `result`/`error` are updated.
- `busy` out 1: high from the cycle after accept through the DONE cycle.
- `error` out 1: set with `done` when operands are invalid; held like `result`.

## Operation
- Reset values: `result`=0, `done`=0, `busy`=0, `error`=0, state=IDLE, all internal registers 0.
- **IDLE:** on `start`=1, latch `msg`, `n` and the selected key (`mode` ? `d_key` : `e_key`) into internal registers, then go to CHECK. Later input changes have no effect on the current operation.
- **CHECK (1 cycle):**
  - If `n` < 2 or `msg` >= `n`: set error_q=1, res_q=0, go to DONE.
  - Otherwise: R=1, B=msg, exponent index k=0, bit counter j=WIDTH-1, go to MUL.
- **MUL:** two interleaved shift-add modular multipliers run in parallel, one operand bit per cycle, MSB first over j = WIDTH-1 down to 0.
  - P1 computes R·B mod n using the bits of R.
  - P2 computes B·B mod n using the bits of B.
  - Per cycle, for each accumulator `acc` and scanned bit `a[j]`:
    - t = 2·acc; if t >= n then t −= n.
    - If a[j]=1: t += b; if t >= n then t −= n.
    - acc = t.
  - Internal width is WIDTH+1 bits, so there is no overflow. Accumulators stay < n.
  - At j=0, commit:
    - If key[k]=1: R ← P1 (final value); otherwise R is unchanged. P1 is computed either way.
    - B ← P2.
    - Clear the accumulators and reload j=WIDTH-1.
    - If k=EXP_WIDTH-1, go to DONE; else k++.
- **DONE (1 cycle):** drive `done`=1; `result` ← R (or 0 on error); `error` ← error_q; then go to IDLE.
- A `start` pulse that arrives during the DONE cycle is ignored. A new request is accepted only in IDLE.
- Arithmetic edge cases:
  - key=0 gives result=1.
  - msg=0 gives result=0, for any key ≠ 0.
  - msg=1 gives result=1.
- Reset asserted mid-operation: everything clears immediately. No `done` is produced for the aborted request. After reset release the block returns to IDLE with `result`=0.

## Timing
- `start` sampled at edge T gives CHECK in cycle T+1 and `busy`=1 from T+1.
- Valid operands: MUL occupies EXP_WIDTH·WIDTH cycles; `done` pulses in cycle T+2+EXP_WIDTH·WIDTH. This is 16386 cycles at the 128/128 defaults, and 258 cycles at 16/16.
- Invalid operands: `done` with `error`=1 in cycle T+2.
- `busy` falls in the cycle after `done`. The earliest next accept is the edge after DONE.
- `result` and `error` change only on the edge that raises `done`.
- Latency is independent of key value and Hamming weight.

## Test plan
- WIDTH=16, EXP_WIDTH=16, n=2773, e=17, d=157, mode=0, msg=65 → `done` exactly 258 cycles after start, `result`=332, `error`=0, `busy` high 258 cycles.
- Same parameters, mode=1, msg=332 → `result`=65. Repeat with e=17 and msg=1 → `result`=1; msg=0 → `result`=0; key=0 → `result`=1.
- msg=2773 (= n), then n=1 with msg=0 → `done` 2 cycles after start, `error`=1, `result`=0. A following valid request clears `error`.
- Second `start` pulsed at cycle 100 of a running operation, and again in the DONE cycle → both ignored. Only one `done`, with the first request's value. Change `msg`/`mode` mid-operation → result unaffected.
- Assert `reset` low at cycle 150 of an operation → `busy`/`done`/`result`/`error` go 0 asynchronously and no `done` follows. A request after release completes normally with the correct value.
- Default 128/128 parameters, n=2773, e=17, msg=65 → `result`=332 after 16386 cycles. Randomised valid operands checked against a reference model for both modes.
